// File: rtl/pipeline_deliver_elastic.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_deliver_elastic
//  Brief    : DEPTH-stage elastic valid/ready pipeline with bubble collapsing,
//             synchronous flush and registered occupancy count.
//  Revision : 1.0 - initial release
// ============================================================================
module pipeline_deliver_elastic #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] occupancy
);

    logic [DEPTH-1:0]            r_v;
    logic [DEPTH-1:0][WIDTH-1:0] r_d;
    logic [CNT_W-1:0]            r_occ;

    logic [DEPTH-1:0]            w_rdy;
    logic [DEPTH-1:0]            w_src_v;
    logic [DEPTH-1:0][WIDTH-1:0] w_src_d;
    logic                        w_in_fire;
    logic                        w_out_fire;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            // Stage gi can advance if any stage from gi to the tail has a hole,
            // or the tail is draining; this is the unrolled ready chain.
            assign w_rdy[gi] = out_ready | ~(&r_v[DEPTH-1:gi]);
            if (gi == 0) begin : g_head
                assign w_src_v[gi] = w_in_fire;
                assign w_src_d[gi] = in_data;
            end else begin : g_body
                assign w_src_v[gi] = r_v[gi-1];
                assign w_src_d[gi] = r_d[gi-1];
            end
        end
    endgenerate

    assign in_ready   = w_rdy[0] & ~flush;
    assign w_in_fire  = in_valid & in_ready;
    assign out_valid  = r_v[DEPTH-1];
    assign out_data   = r_d[DEPTH-1];
    assign w_out_fire = out_valid & out_ready;
    assign occupancy  = r_occ;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v   <= '0;
            r_d   <= '0;
            r_occ <= '0;
        end else if (flush) begin
            r_v   <= '0;
            r_occ <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_rdy[i]) begin
                    r_v[i] <= w_src_v[i];
                    // Payload only moves with a valid source so an empty tail keeps its stale data
                    if (w_src_v[i]) begin
                        r_d[i] <= w_src_d[i];
                    end
                end
            end
            r_occ <= r_occ + CNT_W'(w_in_fire) - CNT_W'(w_out_fire);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_deliver_elastic.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_deliver_elastic
//  Brief    : Directed and random self-checking bench, WIDTH=8 DEPTH=3.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_deliver_elastic;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready = 1'b0;
    logic [CNT_W-1:0] occupancy;

    pipeline_deliver_elastic #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Pre-edge samples of the current cycle
    logic             s_rdy;
    logic             s_ov;
    logic [WIDTH-1:0] s_od;
    logic [CNT_W-1:0] s_occ;
    bit               s_acc;
    bit               s_del;

    // Scoreboard state
    logic [WIDTH-1:0] q[$];
    int               m_occ  = 0;
    bit               inited = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, sample before the edge, then update the model after it.
    task automatic cyc(input logic r, input logic fl, input logic v,
                       input logic [WIDTH-1:0] d, input logic ordy);
        rst       = r;
        flush     = fl;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        #1;
        s_rdy = in_ready;
        s_ov  = out_valid;
        s_od  = out_data;
        s_occ = occupancy;
        s_acc = v && s_rdy;
        s_del = s_ov && ordy;
        if (inited && !r) begin
            chk("occ_model", s_occ, m_occ);
            if (s_ov) begin
                chk("sb_pending", q.size() > 0, 1);
                if (q.size() > 0) chk("sb_data", s_od, q[0]);
            end
        end
        @(posedge clk);
        #1;
        if (r) begin
            q.delete();
            m_occ  = 0;
            inited = 1'b1;
        end else if (fl) begin
            q.delete();
            m_occ = 0;
        end else if (inited) begin
            if (s_del && q.size() > 0) void'(q.pop_front());
            if (s_acc) q.push_back(d);
            m_occ = m_occ + int'(s_acc) - int'(s_del);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] bp[4];
        int sent, got, c, first_acc, first_ov, acc, del;
        bp[0] = 8'h11; bp[1] = 8'h22; bp[2] = 8'h33; bp[3] = 8'h44;

        // Reset
        cyc(1, 0, 0, 8'h00, 0);
        cyc(1, 0, 0, 8'h00, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_occupancy", occupancy, 0);

        // Streaming 0x01..0x0A with out_ready held high
        sent = 0; got = 0; c = 0; first_acc = -1; first_ov = -1;
        while (got < 10 && c < 40) begin
            cyc(0, 0, sent < 10, 8'(sent + 1), 1);
            if (c == 0) chk("rdy_after_reset", s_rdy, 1);
            if (s_ov && first_ov < 0) first_ov = c;
            if (s_acc) begin
                if (first_acc < 0) first_acc = c;
                sent++;
            end
            if (s_del) begin
                chk("stream_data", s_od, 8'(got + 1));
                got++;
            end
            if (c == 5) chk("stream_occ", s_occ, 3);
            c++;
        end
        chk("stream_count", got, 10);
        chk("stream_latency", first_ov - first_acc, 3);
        chk("stream_cycles", c, 13);

        // Backpressure fill
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, bp[i], 0);
            chk("bp_accept", s_rdy, 1);
        end
        cyc(0, 0, 1, bp[3], 0);
        chk("bp_full_rdy", s_rdy, 0);
        chk("bp_full_occ", s_occ, 3);
        cyc(0, 0, 1, bp[3], 1);
        chk("bp_release_rdy", s_rdy, 1);
        chk("bp_out_valid", s_ov, 1);
        chk("bp_out", s_od, 8'h11);
        for (int i = 1; i < 4; i++) begin
            cyc(0, 0, 0, 8'h00, 1);
            chk("bp_out_valid", s_ov, 1);
            chk("bp_out", s_od, bp[i]);
        end
        cyc(0, 0, 0, 8'h00, 1);
        chk("bp_empty", s_ov, 0);

        // Bubble collapse
        cyc(0, 0, 1, 8'hA0, 0);
        cyc(0, 0, 0, 8'h00, 0);
        cyc(0, 0, 0, 8'h00, 0);
        cyc(0, 0, 1, 8'hB0, 0);
        chk("bub_accept", s_rdy, 1);
        cyc(0, 0, 0, 8'h00, 0);
        chk("bub_occ", s_occ, 2);
        cyc(0, 0, 0, 8'h00, 1);
        chk("bub_first_valid", s_ov, 1);
        chk("bub_first", s_od, 8'hA0);
        cyc(0, 0, 0, 8'h00, 1);
        chk("bub_second_valid", s_ov, 1);
        chk("bub_second", s_od, 8'hB0);
        cyc(0, 0, 0, 8'h00, 1);
        chk("bub_empty", s_ov, 0);

        // Flush with a concurrent input offer
        cyc(0, 0, 1, 8'h61, 0);
        cyc(0, 0, 1, 8'h62, 0);
        cyc(0, 0, 1, 8'h63, 0);
        cyc(0, 1, 1, 8'h55, 0);
        chk("flush_rdy", s_rdy, 0);
        cyc(0, 0, 0, 8'h00, 1);
        chk("flush_out_valid", s_ov, 0);
        chk("flush_occ", s_occ, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 8'h00, 1);
            chk("flush_no_leak", s_ov, 0);
        end

        // Reset mid-stream, with flush also asserted
        cyc(0, 0, 1, 8'h71, 0);
        cyc(0, 0, 1, 8'h72, 0);
        cyc(1, 1, 0, 8'h00, 0);
        chk("midrst_pre_occ", s_occ, 2);
        cyc(0, 0, 1, 8'h7E, 1);
        chk("midrst_out_valid", s_ov, 0);
        chk("midrst_out_data", s_od, 8'h00);
        chk("midrst_occ", s_occ, 0);
        chk("midrst_rdy", s_rdy, 1);
        cyc(0, 0, 0, 8'h00, 1);
        chk("midrst_lat1", s_ov, 0);
        cyc(0, 0, 0, 8'h00, 1);
        chk("midrst_lat2", s_ov, 0);
        cyc(0, 0, 0, 8'h00, 1);
        chk("midrst_fresh_valid", s_ov, 1);
        chk("midrst_fresh", s_od, 8'h7E);

        // Random traffic, checked by the scoreboard inside cyc
        acc = 0; del = 0; c = 0;
        while (del < 1000 && c < 20000) begin
            cyc(0, 0, (acc < 1000) && ($urandom_range(0, 1) == 1), 8'($urandom),
                $urandom_range(0, 1) == 1);
            if (s_acc) acc++;
            if (s_del) del++;
            c++;
        end
        chk("rand_delivered", del, 1000);
        chk("rand_drained_occ", m_occ, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_deliver_elastic.md
# pipeline_deliver_elastic

Parametrised successor to the plain per-stage pipeline register. It provides a DEPTH-stage elastic pipeline of WIDTH-bit payloads with a valid/ready handshake on both ends, per-stage bubble collapsing, synchronous flush and an occupancy count. The CPU uses it between pipeline stages wherever a downstream stall or a branch/exception flush must be absorbed without losing or duplicating data.

## Interface
- WIDTH, 32: payload width in bits (>=1).
- DEPTH, 2: number of register stages (>=1).
- CNT_W, $clog2(DEPTH+1): width of the occupancy output (derived; not overridden).

Ports (clock and reset first):
- clk  input  1  clock; all state updates on the posedge.
- rst  input  1  reset, synchronous, active-high.
- flush  input  1  synchronous clear of all stage valid bits.
- in_valid  input  1  upstream has a payload on in_data.
- in_data  input  WIDTH  upstream payload.
- in_ready  output  1  pipeline accepts in_data this cycle.
- out_valid  output  1  stage DEPTH-1 holds a valid payload.
- out_data  output  WIDTH  payload of stage DEPTH-1.
- out_ready  input  1  downstream consumes out_data this cycle.
- occupancy  output  CNT_W  number of valid stages (registered).

## Operation
- Each stage i (0..DEPTH-1) holds v[i] and d[i]. Stage 0 is the input side; stage DEPTH-1 drives out_valid/out_data directly from registers.
- Stage ready: r[DEPTH-1] = !v[DEPTH-1] | out_ready; r[i] = !v[i] | r[i+1] for i<DEPTH-1. The ready chain is combinational, so bubbles collapse in one cycle.
- in_ready = r[0] & !flush.
- Move into stage i+1 when v[i] & r[i+1]; stage i then loads from stage i-1 (or from the input for stage 0) when r[i] holds. Otherwise it keeps its value.
- Stage 0 loads when in_valid & in_ready; v[0] <= 1. If r[0] holds but there is no accepted input, v[0] <= 0.
- Transfers: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Flush (when not in reset): all v[i] <= 0 on the next edge and occupancy <= 0. No input is accepted, because in_ready is 0. An out_fire occurring in the flush cycle counts as delivered. d[i] keeps its value.
- Reset: all v[i] <= 0, all d[i] <= 0, occupancy <= 0. rst has priority over flush.
- Occupancy update: occupancy <= occupancy + in_fire - out_fire when no flush/rst is active. It never exceeds DEPTH and never underflows.
- Order is strictly FIFO. No payload is duplicated or dropped except on flush or rst.

## Timing
- Reset values: out_valid=0, out_data=0, occupancy=0. in_ready=1 in the cycle after rst deasserts, provided flush=0.
- Latency: a payload accepted at edge N (pipeline empty, out_ready=1) appears with out_valid=1 after edge N+DEPTH-1. It is consumed at edge N+DEPTH.
- Throughput: 1 payload/cycle while out_ready=1.
- Full condition: all v=1 and out_ready=0. in_ready then drops to 0 combinationally in the same cycle.
- Full with out_ready=1: in_ready=1. Simultaneous in_fire and out_fire are allowed and leave occupancy unchanged.
- Empty: out_valid=0. out_data holds its stale value; it is checked only when out_valid=1.
- Mid-stream reset or flush: the pipeline is empty on the next cycle, with out_valid=0. In-flight payloads are discarded.
- Combinational paths: out_ready→in_ready and flush→in_ready. There is no path from in_valid to out_valid.

## Test plan
Configuration: WIDTH=8, DEPTH=3.
- Streaming: rst for 2 cycles, then send 0x01..0x0A back-to-back with out_ready=1. The first out_valid appears 2 cycles after the first accept. Outputs are 0x01..0x0A in order, 1 per cycle. occupancy settles at 3.
- Backpressure fill: out_ready=0, in_valid=1 with 0x11,0x22,0x33,0x44. Only 3 payloads are accepted and in_ready=0 on the 4th. occupancy=3. Then out_ready=1 gives outputs 0x11,0x22,0x33,0x44, with in_ready=1 in that same cycle.
- Bubble collapse: load 0xA0, idle 2 cycles, send 0xB0 with out_ready=0. Both payloads are packed in stages 2 and 1 and occupancy=2. Releasing out_ready yields 0xA0 then 0xB0 on consecutive cycles.
- Flush: with 3 entries, assert flush for 1 cycle alongside in_valid=1 (0x55). in_ready=0 in that cycle, then out_valid=0 and occupancy=0 on the next cycle. 0x55 never appears.
- Reset mid-stream: assert rst while occupancy=2 and flush=1. Next cycle out_valid=0, out_data=0x00, occupancy=0. After release, a fresh payload 0x7E emerges with the normal 2-cycle latency.
- Random: random in_valid/out_ready at 50%, 1000 payloads. A scoreboard confirms in-order, lossless delivery, and that occupancy equals accepted minus delivered every cycle.
